// File: rtl/differential_encoder_tx_if.sv
// Stream bundle for the differential encoder: dibit input stream and encoded symbol output stream.
// The master modport is the encoder side. The slave modport is the source/sink environment.
interface differential_encoder_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_dibit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_dibit;
  logic       out_last;

  modport master (
    input  in_valid, in_dibit, in_last, out_ready,
    output in_ready, out_valid, out_dibit, out_last
  );

  modport slave (
    output in_valid, in_dibit, in_last, out_ready,
    input  in_ready, out_valid, out_dibit, out_last
  );
endinterface

// File: rtl/differential_encoder_tx.sv
// Differential (Gray-coded quarter-phase) encoder with a per-frame reference preamble.
// Each frame emits REF_SYMS zero-phase symbols, then one accumulated-phase symbol per input dibit.
module differential_encoder_tx #(
  parameter int unsigned REF_SYMS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  differential_encoder_tx_if.master bus,
  output logic [15:0]               frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] REF_LAST = 4'(REF_SYMS - 1);

  function automatic logic [1:0] phase_inc(input logic [1:0] d);
    case (d)
      2'b00:   phase_inc = 2'd0;
      2'b01:   phase_inc = 2'd1;
      2'b11:   phase_inc = 2'd2;
      default: phase_inc = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] phase_sym(input logic [1:0] p);
    case (p)
      2'd0:    phase_sym = 2'b00;
      2'd1:    phase_sym = 2'b01;
      2'd2:    phase_sym = 2'b11;
      default: phase_sym = 2'b10;
    endcase
  endfunction

  state_t     state, state_nx;
  logic [3:0] ref_cnt, ref_cnt_nx;
  logic [1:0] ph, ph_nx;
  logic [1:0] ph_sum;
  logic       slot_free;
  logic       load;
  logic [1:0] load_dibit;
  logic       load_last;
  logic       fc_inc;

  assign slot_free = !bus.out_valid || bus.out_ready;
  // The 2-bit sum wraps modulo 4 on its own.
  assign ph_sum    = ph + phase_inc(bus.in_dibit);

  always_comb begin
    state_nx     = state;
    ref_cnt_nx   = ref_cnt;
    ph_nx        = ph;
    load         = 1'b0;
    load_dibit   = 2'b00;
    load_last    = 1'b0;
    fc_inc       = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nx   = REF;
          ref_cnt_nx = '0;
        end
      end
      REF: begin
        if (slot_free) begin
          load       = 1'b1;
          ph_nx      = 2'd0;
          ref_cnt_nx = ref_cnt + 4'd1;
          if (ref_cnt == REF_LAST) state_nx = DATA;
        end
      end
      DATA: begin
        // Ready reflects only the output slot, never in_valid.
        bus.in_ready = slot_free;
        if (bus.in_valid && slot_free) begin
          ph_nx      = ph_sum;
          load       = 1'b1;
          load_dibit = phase_sym(ph_sum);
          load_last  = bus.in_last;
          if (bus.in_last) begin
            state_nx = IDLE;
            fc_inc   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state: FSM, reference counter, accumulated phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ref_cnt <= '0;
      ph      <= '0;
    end else begin
      state   <= state_nx;
      ref_cnt <= ref_cnt_nx;
      ph      <= ph_nx;
    end
  end

  // Output register: a load wins over a drain, so drain+reload keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_dibit <= 2'b00;
      bus.out_last  <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_dibit <= load_dibit;
      bus.out_last  <= load_last;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (fc_inc) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule
